// File: rtl/mmio_spi_master.sv
// MMIO SPI master: TX/RX byte FIFOs behind the controller's SPI strobes,
// mode-0 shift engine with registered sck/mosi/cs_n.
module mmio_spi_master #(
  parameter int FIFO_DEPTH = 8,
  parameter int CLK_DIV    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_wr,
  input  logic       spi_rd,
  input  logic       spi_addr,
  input  logic [7:0] spi_din,
  input  logic       spi_ignore_response,
  output logic [7:0] spi_dout,
  output logic       spi_buffer_full,
  output logic       spi_buffer_empty,
  output logic       spi_data_avail,
  output logic       sck,
  output logic       mosi,
  input  logic       miso,
  output logic       cs_n
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_cnt;
  logic [6:0]    tx_shift;
  logic [7:0]    rx_shift;
  logic          ign;

  // TX FIFO: {ignore, data}
  logic [8:0]  tx_mem [FIFO_DEPTH];
  logic [AW:0] tx_wr, tx_rd;
  logic        tx_empty, tx_full, tx_push, tx_pop;
  logic [8:0]  tx_head;

  // RX FIFO, show-ahead
  logic [7:0]  rx_mem [FIFO_DEPTH];
  logic [AW:0] rx_wr, rx_rd;
  logic        rx_empty, rx_full, rx_push, rx_pop;

  assign tx_empty = (tx_wr == tx_rd);
  assign tx_full  = (tx_wr[AW] != tx_rd[AW]) && (tx_wr[AW-1:0] == tx_rd[AW-1:0]);
  assign tx_push  = spi_wr && !spi_addr && !tx_full;
  assign tx_pop   = ((state == ST_IDLE) || (state == ST_DONE)) && !tx_empty;
  assign tx_head  = tx_mem[tx_rd[AW-1:0]];

  assign rx_empty = (rx_wr == rx_rd);
  assign rx_full  = (rx_wr[AW] != rx_rd[AW]) && (rx_wr[AW-1:0] == rx_rd[AW-1:0]);
  assign rx_push  = (state == ST_DONE) && !ign && !rx_full;
  assign rx_pop   = spi_rd && !spi_addr && !rx_empty;

  assign spi_dout         = rx_empty ? '0 : rx_mem[rx_rd[AW-1:0]];
  assign spi_buffer_full  = tx_full;
  assign spi_buffer_empty = tx_empty && (state == ST_IDLE);
  assign spi_data_avail   = !rx_empty;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr[AW-1:0]] <= {spi_ignore_response, spi_din};
    if (rx_push) rx_mem[rx_wr[AW-1:0]] <= rx_shift;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wr <= '0;
      tx_rd <= '0;
      rx_wr <= '0;
      rx_rd <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + 1'b1;
      if (tx_pop)  tx_rd <= tx_rd + 1'b1;
      if (rx_push) rx_wr <= rx_wr + 1'b1;
      if (rx_pop)  rx_rd <= rx_rd + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      ign      <= 1'b0;
      sck      <= 1'b0;
      mosi     <= 1'b0;
      cs_n     <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          cs_n <= 1'b1;
          sck  <= 1'b0;
          if (!tx_empty) begin
            tx_shift <= tx_head[6:0];
            ign      <= tx_head[8];
            mosi     <= tx_head[7];
            cs_n     <= 1'b0;
            cnt      <= '0;
            state    <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cnt == DIV_LAST) begin
            cnt     <= '0;
            bit_cnt <= '0;
            state   <= ST_SHIFT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_SHIFT: begin
          // each half-period lasts CLK_DIV cycles; the level of sck tells which half we are in
          if (cnt == DIV_LAST) begin
            cnt <= '0;
            if (!sck) begin
              sck      <= 1'b1;
              rx_shift <= {rx_shift[6:0], miso};
            end else begin
              sck <= 1'b0;
              if (bit_cnt == 3'd7) begin
                state <= ST_DONE;
              end else begin
                bit_cnt  <= bit_cnt + 3'd1;
                mosi     <= tx_shift[6];
                tx_shift <= {tx_shift[5:0], 1'b0};
              end
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          // back-to-back bytes skip SETUP and keep cs_n asserted
          if (!tx_empty) begin
            tx_shift <= tx_head[6:0];
            ign      <= tx_head[8];
            mosi     <= tx_head[7];
            cnt      <= '0;
            bit_cnt  <= '0;
            state    <= ST_SHIFT;
          end else begin
            cs_n  <= 1'b1;
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule
